// File: rtl/axis_header_insert_mb.sv
// axis_header_insert_mb: prepends 0..MAX_HDR_BEATS header beats to every
// AXI-Stream frame. Header beat 0 carries the frame size and sequence number.
// The payload passes through a single registered output slot.
// Optional build macro HDR_LEN_CHECK_EN: payload byte count check with a
// one-cycle LEN_ERR pulse after the TLAST handshake.
module axis_header_insert_mb #(
  parameter int DW            = 512,
  parameter int MAX_HDR_BEATS = 4,
  parameter int HBW           = $clog2(MAX_HDR_BEATS+1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [31:0]                 FRAME_SIZE,
  input  logic [HBW-1:0]              HDR_BEATS,
  input  logic [MAX_HDR_BEATS*DW-1:0] HDR_DATA,
  input  logic [DW-1:0]               AXIS_IN_TDATA,
  input  logic                        AXIS_IN_TVALID,
  input  logic [DW/8-1:0]             AXIS_IN_TKEEP,
  input  logic                        AXIS_IN_TLAST,
  output logic                        AXIS_IN_TREADY,
  output logic [DW-1:0]               AXIS_OUT_TDATA,
  output logic                        AXIS_OUT_TVALID,
  output logic [DW/8-1:0]             AXIS_OUT_TKEEP,
  output logic                        AXIS_OUT_TLAST,
  input  logic                        AXIS_OUT_TREADY,
  output logic [31:0]                 SEQ_NUM,
  output logic                        LEN_ERR
);

  localparam logic [HBW-1:0] NH_MAX = HBW'(MAX_HDR_BEATS);
  localparam logic [HBW-1:0] NH_ONE = HBW'(1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                      state_q, state_d;
  logic [HBW-1:0]              cnt_q, cnt_d;
  logic [HBW-1:0]              nh_q, nh_in;
  logic [MAX_HDR_BEATS*DW-1:0] hdr_q;
  logic [31:0]                 seq_q;
  logic [DW-1:0]               tdata_q, tdata_d;
  logic [DW/8-1:0]             tkeep_q, tkeep_d;
  logic                        tlast_q, tlast_d;
  logic                        tvalid_q;
  logic                        slot_free, start, hs_in, load;
  logic [DW-1:0]               beat0, hdr_beat;

  // Shared handshake terms used by both FSM processes and the datapath
  always_comb begin
    slot_free = !tvalid_q || AXIS_OUT_TREADY;
    nh_in     = (HDR_BEATS > NH_MAX) ? NH_MAX : HDR_BEATS;
    start     = (state_q == IDLE) && AXIS_IN_TVALID && slot_free;
    hs_in     = (state_q == PAYLOAD) && slot_free && AXIS_IN_TVALID;
    // Beat 0 is built from live inputs because it is loaded on the same
    // edge that latches them.
    beat0        = HDR_DATA[DW-1:0];
    beat0[63:0]  = {seq_q, FRAME_SIZE};
    hdr_beat     = hdr_q[int'(cnt_q)*DW +: DW];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state: header beat sequencing and frame boundaries
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nh_in == '0) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d   = NH_ONE;
            state_d = (nh_in == NH_ONE) ? PAYLOAD : HEADER;
          end
        end
      end
      HEADER: begin
        if (slot_free) begin
          cnt_d = cnt_q + NH_ONE;
          if (cnt_q == nh_q - NH_ONE) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (hs_in && AXIS_IN_TLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: upstream ready and what to load into the output slot
  always_comb begin
    AXIS_IN_TREADY = (state_q == PAYLOAD) && slot_free;
    load    = 1'b0;
    tdata_d = '0;
    tkeep_d = '0;
    tlast_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && nh_in != '0) begin
          load    = 1'b1;
          tdata_d = beat0;
          tkeep_d = '1;
        end
      end
      HEADER: begin
        if (slot_free) begin
          load    = 1'b1;
          tdata_d = hdr_beat;
          tkeep_d = '1;
        end
      end
      PAYLOAD: begin
        if (hs_in) begin
          load    = 1'b1;
          tdata_d = AXIS_IN_TDATA;
          tkeep_d = AXIS_IN_TKEEP;
          tlast_d = AXIS_IN_TLAST;
        end
      end
      default: ;
    endcase
  end

  // Output slot: load when free, drop valid once consumed, hold while stalled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
    end else if (slot_free) begin
      tvalid_q <= 1'b0;
    end
  end

  // Per-frame header snapshot; contents are don't-care until first start
  always_ff @(posedge clk) begin
    if (start) hdr_q <= HDR_DATA;
  end

  // Header beat count and sequence number
  always_ff @(posedge clk) begin
    if (!resetn) begin
      nh_q  <= '0;
      seq_q <= '0;
    end else begin
      if (start) nh_q <= nh_in;
      if (hs_in && AXIS_IN_TLAST) seq_q <= seq_q + 32'd1;
    end
  end

  assign AXIS_OUT_TDATA  = tdata_q;
  assign AXIS_OUT_TVALID = tvalid_q;
  assign AXIS_OUT_TKEEP  = tkeep_q;
  assign AXIS_OUT_TLAST  = tlast_q;
  assign SEQ_NUM         = seq_q;

`ifdef HDR_LEN_CHECK_EN
  logic [31:0] fsize_q, acc_q, pc;
  logic        lerr_q;

  function automatic logic [31:0] popcount(input logic [DW/8-1:0] k);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < DW/8; i++) n = n + {31'd0, k[i]};
    return n;
  endfunction

  // Byte count of the current payload beat
  always_comb pc = popcount(AXIS_IN_TKEEP);

  // Accumulate payload bytes; compare against latched size on TLAST
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fsize_q <= '0;
      acc_q   <= '0;
      lerr_q  <= 1'b0;
    end else begin
      lerr_q <= 1'b0;
      if (start) begin
        fsize_q <= FRAME_SIZE;
        acc_q   <= '0;
      end else if (hs_in) begin
        if (AXIS_IN_TLAST) begin
          lerr_q <= (acc_q + pc) != fsize_q;
          acc_q  <= '0;
        end else begin
          acc_q  <= acc_q + pc;
        end
      end
    end
  end

  assign LEN_ERR = lerr_q;
`else
  assign LEN_ERR = 1'b0;
`endif

endmodule
